// File: rtl/regfile_wb_pkg.sv
// Shared core constants: default datapath widths and the hardwired-zero register address.
package regfile_wb_pkg;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_ADDR_W   = 3;
   localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_wb_stage_reg.sv
// One-entry write-back register: captures the ALU result, flags it pending for one
// cycle and compares it against both read addresses for forwarding.
module wb_stage_reg
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_en,
   input  logic              stall,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              pending,
   output logic [ADDR_W-1:0] commit_addr,
   output logic [DATA_W-1:0] commit_data,
   output logic              fwd1,
   output logic              fwd2
);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic              pending_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              live;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= 1'b0;
         addr_reg    <= '0;
         data_reg    <= '0;
      end else if (wb_en && !stall) begin
         pending_reg <= 1'b1;
         addr_reg    <= wb_addr;
         data_reg    <= wb_data;
      end else begin
         // A stalled request is dropped; addr/data hold but are no longer live.
         pending_reg <= 1'b0;
      end
   end

   // A pending write to r0 never forwards.
   assign live        = pending_reg && (addr_reg != ZERO_ADDR);
   assign fwd1        = live && (addr_reg == rs1_addr);
   assign fwd2        = live && (addr_reg == rs2_addr);
   assign pending     = pending_reg;
   assign commit_addr = addr_reg;
   assign commit_data = data_reg;
endmodule

// File: rtl/regfile_wb.sv
// Register file with r0 hardwired to zero, fed by a one-entry write-back stage
// whose pending value is forwarded to both read ports.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              stall,
   output logic              wb_pending,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs_reg [NUM_REGS];
   logic              pending;
   logic [ADDR_W-1:0] commit_addr;
   logic [DATA_W-1:0] commit_data;
   logic              fwd1;
   logic              fwd2;
   logic              commit_en;

   logic [ADDR_W-1:0] rs_addr [2];
   logic              fwd     [2];
   logic [DATA_W-1:0] rd_data [2];

   wb_stage_reg #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_wb_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_en      (wb_en),
      .stall      (stall),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .pending    (pending),
      .commit_addr(commit_addr),
      .commit_data(commit_data),
      .fwd1       (fwd1),
      .fwd2       (fwd2)
   );

   assign commit_en = pending && (commit_addr != ZERO_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (commit_en) begin
         regs_reg[commit_addr] <= commit_data;
      end
   end

   assign rs_addr[0] = rs1_addr;
   assign rs_addr[1] = rs2_addr;
   assign fwd[0]     = fwd1;
   assign fwd[1]     = fwd2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_read
         always_comb begin
            rd_data[gi] = '0;
            if (rs_addr[gi] != ZERO_ADDR) begin
               rd_data[gi] = fwd[gi] ? commit_data : regs_reg[rs_addr[gi]];
            end
         end
      end
   endgenerate

   assign rd1_data   = rd_data[0];
   assign rd2_data   = rd_data[1];
   assign wb_pending = pending;
   // r0 is never committed, so the raw array read is already zero there.
   assign dbg_data   = regs_reg[dbg_addr];
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 8-bit register file with a registered write-back stage for the single-cycle core.
- Sits directly around the ALU:
  - Upstream, its two read ports supply the ALU A/B operands (A feeds the addi path; B feeds the mov path).
  - Downstream, it captures the ALU Result into a one-entry write-back register and commits it to the array on the next edge.
- Forwards the pending write-back value to the read ports so back-to-back dependent instructions see fresh data.

Parameters:
- DATA_W, 8, register and data width in bits.
- NUM_REGS, 8, number of architectural registers.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W == NUM_REGS.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  ADDR_W  read port 1 address (ALU A operand).
- rs2_addr  input  ADDR_W  read port 2 address (ALU B operand).
- rd1_data  output  DATA_W  read port 1 data, combinational.
- rd2_data  output  DATA_W  read port 2 data, combinational.
- wb_en  input  1  write request for the current instruction.
- wb_addr  input  ADDR_W  destination register.
- wb_data  input  DATA_W  value to write (ALU Result).
- stall  input  1  freezes write-back capture; commit of an already-pending entry still proceeds.
- wb_pending  output  1  write-back register holds an uncommitted entry.
- dbg_addr  input  ADDR_W  debug read address, array only.
- dbg_data  output  DATA_W  committed array contents at dbg_addr, no forwarding.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All array entries = 0.
  - wb_pending = 0; wb register addr/data = 0.
  - rd1_data, rd2_data and dbg_data therefore read 0 while in reset.
- Register 0 is hardwired zero:
  - Reads of address 0 return 0 regardless of forwarding.
  - A write to address 0 is captured (wb_pending rises) but never modifies the array and is never forwarded.
- Capture, on each rising edge:
  - If wb_en=1 and stall=0: the wb register loads wb_addr/wb_data and wb_pending <= 1.
  - Else: wb_pending <= 0, and wb addr/data hold their values.
- Commit, on each rising edge:
  - If wb_pending=1 and the wb addr is not 0: array[wb addr] <= wb data.
  - Commit and capture occur on the same edge. A new capture to the same address overwrites the wb register after the old value is committed; both land in order.
- Latency:
  - Instruction issued in cycle N is visible via forwarding in cycle N+1.
  - Visible in the array (dbg_data) in cycle N+2.
- Read ports, combinational:
  - rdX_data = 0 if rsX_addr == 0.
  - Else the wb data if wb_pending and the wb addr == rsX_addr.
  - Else array[rsX_addr].
  - Forwarding has priority over the array.
  - Both ports may forward simultaneously.
- Same-cycle read of the wb_addr currently presented on the input returns the old value (no input-to-output bypass). The instruction's own write is visible from the next cycle.
- Stall:
  - The incoming request is dropped (the core re-presents it).
  - The pending entry still commits, so after one stalled cycle wb_pending = 0.
- Reset mid-operation: a pending entry is discarded (not committed); the array clears.
- Arithmetic: none. Data is passed unmodified at DATA_W; no width conversion.

Decomposition:
- Shared core package holds DATA_W/ADDR_W/NUM_REGS defaults and the REG_ZERO address constant, reused by the ALU and decoder.
- One natural sub-module: wb_stage_reg, which holds the capture register, pending flag and forwarding compare. The array and read muxes stay in regfile_wb.

Test Plan:
- Reset:
  - Hold rst_n=0 mid-run with wb_pending=1.
  - Required: rd1/rd2/dbg_data = 0x00 and wb_pending = 0 immediately, without waiting for a clock.
  - After release, all 8 registers read 0x00.
- Write / forward / commit:
  - wb_en=1, wb_addr=3, wb_data=0x5A in cycle 0; rs1_addr=3.
  - Required: cycle 0 rd1=0x00; cycle 1 rd1=0x5A via forward with dbg_data(3)=0x00; cycle 2 dbg_data(3)=0x5A.
- Back-to-back same address:
  - Write r2=0x11 in cycle 0, r2=0x22 in cycle 1.
  - Required: rd2 (rs2=2) reads 0x11 in cycle 1 and 0x22 in cycle 2; array holds 0x22 at cycle 3.
- Register 0:
  - Write r0=0xFF.
  - Required: wb_pending=1 for one cycle; rd1 (rs1=0) = 0x00 on every cycle; dbg_data(0) = 0x00.
- Stall:
  - Write r5=0x33 with stall=1, while a pending r4=0x44 exists.
  - Required: r4 commits (0x44); r5 unchanged (0x00); wb_pending = 0 the next cycle.
- Dual forward:
  - Pending r7=0x80 with rs1=rs2=7.
  - Required: rd1 = rd2 = 0x80 while the array still reads 0x00.
